// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter:
// bit-timing helper, FSM state encoding and 8N1 frame constants.
package uart_pkg;

  localparam int   FRAME_DATA_BITS = 8;
  localparam logic FRAME_START_LVL = 1'b0;
  localparam logic FRAME_STOP_LVL  = 1'b1;
  localparam logic LINE_IDLE_LVL   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

  function automatic int cycles_per_bit(input int clock_hz, input int bit_rate);
    return clock_hz / bit_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit; both flops
// reset to RST_VAL so the output is defined from the first cycle.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of a synchronized RX line, byte held
// behind a valid/ready handshake, with frame-error, break and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_HZ     = 12_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = FRAME_DATA_BITS
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_ready,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_valid,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_break,
  output logic                    uart_rx_overrun
);

  localparam int CPB   = cycles_per_bit(CLOCK_HZ, BIT_RATE);
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB);
  localparam int IDX_W = $clog2(PAYLOAD_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CPB - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(PAYLOAD_BITS - 1);

  if (CPB < 4) begin : g_cpb_chk
    $fatal(1, "uart_rx: CLOCK_HZ/BIT_RATE must be at least 4");
  end

  logic                    rxs, rxs_d, fall;
  uart_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [PAYLOAD_BITS-1:0] sreg;
  logic                    cnt_clr, idx_clr, data_smp, stop_smp;
  logic                    stop_ok, stop_bad;

  sync_2ff #(.RST_VAL(LINE_IDLE_LVL)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (uart_rxd),
    .q      (rxs)
  );

  assign fall     = !rxs && rxs_d;
  assign stop_ok  = stop_smp && (rxs == FRAME_STOP_LVL);
  assign stop_bad = stop_smp && (rxs != FRAME_STOP_LVL);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Counter is held at zero in IDLE so START always measures from the edge.
  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    idx_clr  = 1'b0;
    data_smp = 1'b0;
    stop_smp = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (fall) state_d = ST_START;
      end
      ST_START: if (cnt == CNT_HALF_END) begin
        cnt_clr = 1'b1;
        idx_clr = 1'b1;
        state_d = (rxs == FRAME_START_LVL) ? ST_DATA : ST_IDLE;
      end
      ST_DATA: if (cnt == CNT_BIT_END) begin
        cnt_clr  = 1'b1;
        data_smp = 1'b1;
        if (idx == IDX_LAST) state_d = ST_STOP;
      end
      ST_STOP: if (cnt == CNT_BIT_END) begin
        cnt_clr  = 1'b1;
        stop_smp = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxs_d             <= LINE_IDLE_LVL;
      cnt               <= '0;
      idx               <= '0;
      sreg              <= '0;
      uart_rx_data      <= '0;
      uart_rx_valid     <= 1'b0;
      uart_rx_frame_err <= 1'b0;
      uart_rx_break     <= 1'b0;
      uart_rx_overrun   <= 1'b0;
    end else begin
      rxs_d <= rxs;
      cnt   <= cnt_clr ? '0 : cnt + 1'b1;
      if (idx_clr)       idx <= '0;
      else if (data_smp) idx <= idx + 1'b1;
      // LSB arrives first, so shifting right leaves bit i in position i.
      if (data_smp) sreg <= {rxs, sreg[PAYLOAD_BITS-1:1]};

      uart_rx_frame_err <= stop_bad;
      uart_rx_break     <= stop_bad && (sreg == '0);
      uart_rx_overrun   <= stop_ok && uart_rx_valid && !uart_rx_ready;

      if (stop_ok && (!uart_rx_valid || uart_rx_ready)) begin
        uart_rx_data  <= sreg;
        uart_rx_valid <= 1'b1;
      end else if (uart_rx_valid && uart_rx_ready) begin
        uart_rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: frames are predicted at byte level
// and a negedge monitor matches every accepted byte and error pulse.
module tb_uart_rx;

  localparam int CLOCK_HZ = 1_600_000;
  localparam int BIT_RATE = 100_000;
  localparam int CPB      = 16;
  localparam int HALF     = 8;
  localparam int PB       = 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          uart_rxd = 1'b1;
  logic          uart_rx_ready = 1'b0;
  logic [PB-1:0] uart_rx_data;
  logic          uart_rx_valid, uart_rx_frame_err, uart_rx_break, uart_rx_overrun;

  int total = 0;
  int bad   = 0;

  logic [7:0] data_q[$];
  bit         err_q[$];
  int         ovr_pend = 0;
  bit         hold = 1'b0;
  int         lat = 0;

  always #5 clk = ~clk;

  uart_rx #(.CLOCK_HZ(CLOCK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(PB)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .uart_rxd          (uart_rxd),
    .uart_rx_ready     (uart_rx_ready),
    .uart_rx_data      (uart_rx_data),
    .uart_rx_valid     (uart_rx_valid),
    .uart_rx_frame_err (uart_rx_frame_err),
    .uart_rx_break     (uart_rx_break),
    .uart_rx_overrun   (uart_rx_overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Byte-level outcome of one frame: error entry, dropped byte, or delivery.
  task automatic expect_frame(input logic [7:0] b, input bit stop);
    if (!stop) err_q.push_back(b == 8'h00);
    else if (hold) ovr_pend++;
    else begin
      data_q.push_back(b);
      hold = !uart_rx_ready;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop);
    expect_frame(b, stop);
    uart_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < PB; i++) begin
      uart_rxd = b[i];
      tick(CPB);
    end
    uart_rxd = stop;
    tick(CPB);
    if (!stop) begin
      uart_rxd = 1'b1;
      tick(CPB);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((data_q.size() + err_q.size() + ovr_pend) != 0 && n < budget) begin
      tick(1);
      n++;
    end
    check(name, data_q.size() + err_q.size() + ovr_pend, 0);
    tick(CPB);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_valid"}, uart_rx_valid, 0);
    check({name, "_data"}, uart_rx_data, 0);
    check({name, "_ferr"}, uart_rx_frame_err, 0);
    check({name, "_break"}, uart_rx_break, 0);
    check({name, "_ovr"}, uart_rx_overrun, 0);
  endtask

  logic [7:0] prev_data = '0;
  bit         prev_stall = 1'b0;

  always @(negedge clk) begin
    if (resetn) begin
      if (prev_stall && uart_rx_valid) check("data_stable", uart_rx_data, prev_data);
      if (uart_rx_valid && uart_rx_ready) begin
        if (data_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got %0h expected none", uart_rx_data);
        end else check("rx_data", uart_rx_data, data_q.pop_front());
      end
      if (uart_rx_frame_err) begin
        if (err_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame_err: got 1 expected 0");
        end else check("break_flag", uart_rx_break, err_q.pop_front());
      end else if (uart_rx_break) begin
        total++;
        bad++;
        $display("FAIL break_without_ferr: got 1 expected 0");
      end
      if (uart_rx_overrun) begin
        check("overrun_expected", ovr_pend > 0, 1);
        if (ovr_pend > 0) ovr_pend--;
      end
      prev_stall = uart_rx_valid && !uart_rx_ready;
      prev_data  = uart_rx_data;
    end else prev_stall = 1'b0;
  end

  initial begin
    #600_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    bit         stop;
    int         gap;

    resetn = 1'b0;
    tick(3);
    check_all_zero("reset");
    resetn = 1'b1;
    tick(5);

    // Good frame with stall, plus start-edge-to-valid latency.
    uart_rx_ready = 1'b0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (!uart_rx_valid && lat < 400) begin
          @(posedge clk);
          #2;
          lat++;
        end
      end
    join
    check("valid_latency", (lat >= HALF + 9*CPB + 3) && (lat <= HALF + 9*CPB + 4), 1);
    tick(40);
    check("stall_valid", uart_rx_valid, 1);
    check("stall_data", uart_rx_data, 8'hA5);
    uart_rx_ready = 1'b1;
    hold = 1'b0;
    tick(1);
    check("valid_drop", uart_rx_valid, 0);
    drain("stall_drain", 50);

    // Back-to-back with ready tied high.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    drain("b2b_drain", 100);

    // Short low glitch; a following frame proves the FSM is idle again.
    uart_rxd = 1'b0;
    tick(4);
    uart_rxd = 1'b1;
    tick(3*CPB);
    send_frame(8'h96, 1'b1);
    drain("glitch_drain", 100);

    // Frame error, then a long break with no retrigger while low.
    send_frame(8'h5A, 1'b0);
    tick(2*CPB);
    err_q.push_back(1'b1);
    uart_rxd = 1'b0;
    tick(20*CPB);
    uart_rxd = 1'b1;
    tick(2*CPB);
    drain("break_drain", 100);

    // Overrun: second byte dropped while the first is held.
    uart_rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(CPB);
    check("ovr_valid", uart_rx_valid, 1);
    check("ovr_data", uart_rx_data, 8'h11);
    uart_rx_ready = 1'b1;
    hold = 1'b0;
    drain("ovr_drain", 100);

    // Reset in the middle of bit 4 of 0x77; only the next frame is delivered.
    b = 8'h77;
    uart_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = b[i];
      tick(CPB);
    end
    uart_rxd = b[4];
    tick(HALF);
    resetn = 1'b0;
    uart_rxd = 1'b1;
    tick(1);
    check_all_zero("midreset");
    tick(3);
    resetn = 1'b1;
    tick(CPB);
    send_frame(8'h81, 1'b1);
    drain("midreset_drain", 100);

    // Random frames, some with bad stop bits, some breaks, random gaps.
    for (int k = 0; k < 24; k++) begin
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 7) == 0) b = 8'h00;
      send_frame(b, stop);
      gap = $urandom_range(0, 2) * HALF;
      if (gap > 0) tick(gap);
    end
    drain("random_drain", 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: the receive-side counterpart of the `tx` transmitter. It recovers 8N1 frames from an asynchronous serial line and delivers each byte through a valid/ready handshake to on-chip logic such as command decoders or LED reporters. It sits directly behind the board's RX pin and shares bit-rate parameters with `tx`, so a `tx`/`uart_rx` pair can be looped back.

## Interface
- `CLOCK_HZ`, 12_000_000, system clock frequency in Hz
- `BIT_RATE`, 9600, line bit rate in bits/s
- `PAYLOAD_BITS`, 8, data bits per frame, LSB first
- `clk`  in  1  system clock; one clock domain; all logic on rising edge
- `resetn`  in  1  reset, asynchronous assert, active-low
- `uart_rxd`  in  1  serial line, asynchronous to `clk`, idles high
- `uart_rx_ready`  in  1  consumer accepts the held byte this cycle
- `uart_rx_data`  out  PAYLOAD_BITS  received byte, stable while valid
- `uart_rx_valid`  out  1  byte held; stays high until accepted
- `uart_rx_frame_err`  out  1  one-cycle pulse: stop bit sampled low
- `uart_rx_break`  out  1  one-cycle pulse: frame error with all data bits 0
- `uart_rx_overrun`  out  1  one-cycle pulse: completed byte dropped, holding register full

## Operation
- `CPB` = CLOCK_HZ / BIT_RATE, integer floor; `HALF` = CPB / 2. Counter width is `$clog2(CPB)`. `CPB < 4` is illegal; simulation fatal at elaboration.
- `uart_rxd` passes through a 2-FF synchronizer with reset value 1. `rxs` is the synchronized signal. A falling edge is `rxs == 0` with the previous `rxs == 1`.
- FSM states and transitions:
  - IDLE: a falling edge moves to START and clears the counter.
  - START: after HALF cycles, sample `rxs`. If 1, the event is a glitch: return to IDLE with no output. If 0, move to DATA with the bit index at 0.
  - DATA: every CPB cycles, sample `rxs` into the shift register at bit index i. After PAYLOAD_BITS samples, move to STOP.
  - STOP: after CPB cycles, sample `rxs`, then return to IDLE.
- Stop sample = 1 (good frame): deliver the byte.
  - If `uart_rx_valid` = 0, or `uart_rx_ready` = 1 in the same cycle: load `uart_rx_data` and set valid.
  - Otherwise keep the old byte, drop the new one, and pulse `uart_rx_overrun`.
- Stop sample = 0: the byte is never delivered. Pulse `uart_rx_frame_err`. If the shift register is all 0, also pulse `uart_rx_break`.
- IDLE re-arms only on a 1→0 edge. A line held low after a break does not retrigger until it returns high and falls again.
- Handshake:
  - valid & ready clears valid on the next edge.
  - `uart_rx_ready` is ignored while valid = 0.
  - Data never changes while valid = 1.
- Reset may occur mid-frame. It forces IDLE, clears the counter and shift register, and sets the synchronizer to 1. The partial frame is discarded.

## Timing
- Let E = the cycle in which `rxs` first reads 0. E is 2–3 cycles after the pin edge.
- Start sample at E+HALF. Data bit i sampled at E+HALF+(i+1)·CPB. Stop sample at E+HALF+(PAYLOAD_BITS+1)·CPB.
- `uart_rx_valid`, `uart_rx_frame_err`, `uart_rx_break` and `uart_rx_overrun` are registered. They change on the edge following the stop sample.
- Pulses are exactly 1 cycle wide.
- Back-to-back frames: a start edge arriving ≥ HALF cycles after the stop sample is caught. Sampling mid-bit tolerates about ±4% rate mismatch.
- Reset values:
  - `uart_rx_data` = 0
  - `uart_rx_valid` = 0
  - `uart_rx_frame_err` = 0
  - `uart_rx_break` = 0
  - `uart_rx_overrun` = 0
  - state = IDLE

## Structure
- Shared package `uart_pkg`, shared with `tx`, holds:
  - the cycles-per-bit constant function
  - the state encoding (IDLE, START, DATA, STOP)
  - the 8N1 frame constants
- One sub-module: `sync_2ff`, a generic 2-flop synchronizer with a reset-value parameter (here 1). Everything else is inline in `uart_rx`.

## Test plan
All scenarios use CLOCK_HZ 1_600_000 and BIT_RATE 100_000, giving CPB 16.
- **Good frame with stall:** send 0xA5, ready held 0. Required: valid rises HALF+9·CPB+1 cycles after E, data 0xA5. Valid stays high until ready, then drops next cycle.
- **Back-to-back with concurrent accept:** send 0x00, 0xFF, 0x3C back-to-back, ready tied 1. Required: three valid pulses with data 0x00, 0xFF, 0x3C and no errors.
- **Glitch rejection:** drive a 4-cycle low pulse on `uart_rxd`. Required: no valid and no error pulses; FSM back in IDLE.
- **Frame error and break:** send 0x5A with stop bit 0. Required: one `uart_rx_frame_err` pulse, valid stays 0. Then hold the line low for 20 bit times. Required: frame_err and break pulse once, with no retrigger until the line goes high.
- **Overrun:** send 0x11, then 0x22, ready held 0. Required: `uart_rx_overrun` pulses once and data remains 0x11.
- **Reset mid-frame:** assert `resetn` low during bit 4 of 0x77, then release and send 0x81. Required: all outputs 0 during reset, only 0x81 delivered.
